// File: rtl/game_controller_pkg.sv
// Shared state codes and command bundle for the memory-game control unit.
package game_controller_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_SETUP  = 4'd1,
    S_PREP   = 4'd2,
    S_SEQ    = 4'd3,
    S_PLAY   = 4'd4,
    S_CHECK  = 4'd5,
    S_NEXT   = 4'd6,
    S_RESULT = 4'd7
  } state_e;

  typedef struct packed {
    logic r1;
    logic r2;
    logic e1;
    logic e2;
    logic e3;
    logic e4;
    logic sel;
  } cmd_t;

  localparam cmd_t CMD_IDLE = '0;

endpackage

// File: rtl/game_controller_if.sv
// Status flags from the datapath and command strobes back to it.
interface game_controller_if;
  logic       enter;
  logic       end_fpga;
  logic       end_user;
  logic       end_time;
  logic       win;
  logic       match;
  logic       r1;
  logic       r2;
  logic       e1;
  logic       e2;
  logic       e3;
  logic       e4;
  logic       sel;
  logic [3:0] state;

  modport master (
    output enter, end_fpga, end_user, end_time, win, match,
    input  r1, r2, e1, e2, e3, e4, sel, state
  );

  modport slave (
    input  enter, end_fpga, end_user, end_time, win, match,
    output r1, r2, e1, e2, e3, e4, sel, state
  );
endinterface

// File: rtl/game_controller_rise_detect.sv
// One-cycle pulse on a rising edge of an already-debounced level.
module game_controller_rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/game_controller.sv
// Moore sequencer for the memory game: setup, FPGA playback, user entry, check, result.
//   state  | meaning
//   INIT   | clear setup, round counter and divider
//   SETUP  | load setup register until enter
//   PREP   | clear per-round counters/registers
//   SEQ    | FPGA plays its sequence
//   PLAY   | user entry with time limit
//   CHECK  | compare user vs FPGA sequence
//   NEXT   | advance round counter by one
//   RESULT | show result, wait for enter or timeout
module game_controller #(
  parameter int unsigned RESULT_HOLD = 250_000_000,
  parameter int unsigned HOLD_W      = 28
) (
  input logic              clock_50,
  input logic              reset,
  game_controller_if.slave bus
);
  import game_controller_pkg::*;

  localparam bit                HOLD_EN   = (RESULT_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EN ? RESULT_HOLD - 1 : 0);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic              w_enter_p;
  logic              w_hold_done;
  cmd_t              w_cmd;

  game_controller_rise_detect u_rise (
    .i_clk  (clock_50),
    .i_rst  (reset),
    .i_d    (bus.enter),
    .o_rise (w_enter_p)
  );

  always_ff @(posedge clock_50) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Counts cycles spent in RESULT; any other state keeps it parked at zero.
  always_ff @(posedge clock_50) begin
    if (reset || (r_state != S_RESULT)) r_hold <= '0;
    else                                r_hold <= r_hold + HOLD_W'(1);
  end

  assign w_hold_done = HOLD_EN && (r_hold == HOLD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:   w_state_nxt = S_SETUP;
      S_SETUP:  if (w_enter_p) w_state_nxt = S_PREP;
      S_PREP:   w_state_nxt = S_SEQ;
      S_SEQ:    if (bus.end_fpga) w_state_nxt = S_PLAY;
      S_PLAY: begin
        // Completion beats timeout when both land in the same cycle.
        if (bus.end_user)      w_state_nxt = S_CHECK;
        else if (bus.end_time) w_state_nxt = S_RESULT;
      end
      S_CHECK:  w_state_nxt = (!bus.match || bus.win) ? S_RESULT : S_NEXT;
      S_NEXT:   w_state_nxt = S_PREP;
      S_RESULT: if (w_enter_p || w_hold_done) w_state_nxt = S_INIT;
      default:  w_state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    w_cmd = CMD_IDLE;
    case (r_state)
      S_INIT: begin
        w_cmd.r1 = 1'b1;
        w_cmd.r2 = 1'b1;
      end
      S_SETUP:  w_cmd.e1  = 1'b1;
      S_PREP:   w_cmd.r2  = 1'b1;
      S_SEQ:    w_cmd.e3  = 1'b1;
      S_PLAY:   w_cmd.e2  = 1'b1;
      S_NEXT:   w_cmd.e4  = 1'b1;
      S_RESULT: w_cmd.sel = 1'b1;
      default:  w_cmd = CMD_IDLE;
    endcase
  end

  assign bus.r1    = w_cmd.r1;
  assign bus.r2    = w_cmd.r2;
  assign bus.e1    = w_cmd.e1;
  assign bus.e2    = w_cmd.e2;
  assign bus.e3    = w_cmd.e3;
  assign bus.e4    = w_cmd.e4;
  assign bus.sel   = w_cmd.sel;
  assign bus.state = r_state;
endmodule

// File: tb/tb_game_controller.sv
// Vector-table bench for game_controller with a short result hold.
module tb_game_controller;
  localparam int unsigned HOLD = 20;

  localparam logic [3:0] ST_INIT   = 4'd0;
  localparam logic [3:0] ST_SETUP  = 4'd1;
  localparam logic [3:0] ST_PREP   = 4'd2;
  localparam logic [3:0] ST_SEQ    = 4'd3;
  localparam logic [3:0] ST_PLAY   = 4'd4;
  localparam logic [3:0] ST_CHECK  = 4'd5;
  localparam logic [3:0] ST_NEXT   = 4'd6;
  localparam logic [3:0] ST_RESULT = 4'd7;

  // Input bits: {reset, enter, end_fpga, end_user, end_time, win, match}
  typedef struct {
    logic [6:0] in;
    logic [3:0] st;
  } vec_t;

  logic clock_50 = 1'b0;
  logic reset;
  always #10 clock_50 = ~clock_50;

  game_controller_if bus ();

  game_controller #(.RESULT_HOLD(HOLD), .HOLD_W(8)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus)
  );

  vec_t       tbl[$];
  logic [3:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;

  // {r1, r2, e1, e2, e3, e4, sel} expected in each state
  function automatic logic [6:0] exp_cmd(input logic [3:0] s);
    case (s)
      ST_INIT:   return 7'b1100000;
      ST_SETUP:  return 7'b0010000;
      ST_PREP:   return 7'b0100000;
      ST_SEQ:    return 7'b0000100;
      ST_PLAY:   return 7'b0001000;
      ST_NEXT:   return 7'b0000010;
      ST_RESULT: return 7'b0000001;
      default:   return 7'b0000000;
    endcase
  endfunction

  function automatic void add(input logic [6:0] in, input logic [3:0] st);
    vec_t v;
    v.in = in;
    v.st = st;
    tbl.push_back(v);
  endfunction

  task automatic apply(input int idx, input logic [6:0] in, input logic [3:0] st);
    logic [3:0] exp_st;
    logic [6:0] got_cmd;
    {reset, bus.enter, bus.end_fpga, bus.end_user, bus.end_time, bus.win, bus.match} = in;
    sb_q.push_back(st);
    @(posedge clock_50);
    #1;
    exp_st  = sb_q.pop_front();
    got_cmd = {bus.r1, bus.r2, bus.e1, bus.e2, bus.e3, bus.e4, bus.sel};
    checks++;
    if (bus.state !== exp_st) begin
      errors++;
      $display("FAIL vec%0d state got %0d want %0d", idx, bus.state, exp_st);
    end
    checks++;
    if (got_cmd !== exp_cmd(exp_st)) begin
      errors++;
      $display("FAIL vec%0d cmd got %b want %b", idx, got_cmd, exp_cmd(exp_st));
    end
  endtask

  initial begin
    reset = 1'b1;
    {bus.enter, bus.end_fpga, bus.end_user, bus.end_time, bus.win, bus.match} = '0;

    // reset, then release into SETUP
    add(7'b1000000, ST_INIT);
    add(7'b1000000, ST_INIT);
    add(7'b0000000, ST_SETUP);
    add(7'b0000000, ST_SETUP);
    // enter held 10 cycles: one PREP, then SEQ waiting for end_fpga
    add(7'b0100000, ST_PREP);
    for (int i = 0; i < 9; i++) add(7'b0100000, ST_SEQ);
    add(7'b0000000, ST_SEQ);
    add(7'b0010000, ST_PLAY);
    add(7'b0000000, ST_PLAY);
    add(7'b0100000, ST_PLAY);   // enter ignored in PLAY
    add(7'b0001001, ST_CHECK);
    add(7'b0001001, ST_NEXT);
    add(7'b0000000, ST_PREP);
    add(7'b0000000, ST_SEQ);
    add(7'b0010000, ST_PLAY);
    // timeout path, then enter returns to INIT
    add(7'b0000100, ST_RESULT);
    add(7'b0000000, ST_RESULT);
    add(7'b0100000, ST_INIT);
    add(7'b0100000, ST_SETUP);
    add(7'b0100000, ST_SETUP);  // held enter gives no second pulse
    add(7'b0000000, ST_SETUP);
    add(7'b0100000, ST_PREP);
    add(7'b0000000, ST_SEQ);
    add(7'b0010000, ST_PLAY);
    // end_user and end_time together, match & win -> CHECK -> RESULT
    add(7'b0001111, ST_CHECK);
    add(7'b0001011, ST_RESULT);
    // hold timeout: 20 cycles in RESULT total, then INIT
    for (int i = 0; i < HOLD - 1; i++) add(7'b0000000, ST_RESULT);
    add(7'b0000000, ST_INIT);
    add(7'b0000000, ST_SETUP);
    // mismatch loses
    add(7'b0100000, ST_PREP);
    add(7'b0000000, ST_SEQ);
    add(7'b0010000, ST_PLAY);
    add(7'b0001000, ST_CHECK);
    add(7'b0001000, ST_RESULT);
    add(7'b0100000, ST_INIT);
    add(7'b0000000, ST_SETUP);
    // reset mid-SEQ and mid-PLAY
    add(7'b0100000, ST_PREP);
    add(7'b0000000, ST_SEQ);
    add(7'b1010000, ST_INIT);
    add(7'b0000000, ST_SETUP);
    add(7'b0100000, ST_PREP);
    add(7'b0000000, ST_SEQ);
    add(7'b0010000, ST_PLAY);
    add(7'b1001100, ST_INIT);
    add(7'b0000000, ST_SETUP);

    foreach (tbl[i]) apply(i, tbl[i].in, tbl[i].st);

    // enter pulse in RESULT well before the hold expires
    apply(1000, 7'b0100000, ST_PREP);
    apply(1001, 7'b0000000, ST_SEQ);
    apply(1002, 7'b0010000, ST_PLAY);
    apply(1003, 7'b0000100, ST_RESULT);
    for (int i = 0; i < 5; i++) apply(1004 + i, 7'b0000000, ST_RESULT);
    apply(1010, 7'b0100000, ST_INIT);
    apply(1011, 7'b0000000, ST_SETUP);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover got %0d want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
